// File: rtl/demux_scheduler.sv
// One-entry holding stage that steers each accepted word to a single output lane,
// chosen round-robin or by the word's destination field, with delivery count and stall flag.
module demux_scheduler #(
    parameter int WIDTH      = 8,
    parameter int NUM_OUT    = 4,
    parameter int STALL_MAX  = 15,
    localparam int SELW      = $clog2(NUM_OUT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SELW-1:0]            in_dest,
    input  logic                       rr_mode,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [NUM_OUT*WIDTH-1:0]   out_data,
    output logic [SELW-1:0]            sel,
    output logic [15:0]                word_cnt,
    output logic                       stall
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]      state_p0;
    logic            tgt_rr_p0;
    logic [SELW-1:0] rr_ptr_p0;
    logic [7:0]      stall_cnt_p0;

    logic            xfer;
    logic            capture;
    logic [SELW-1:0] rr_next;
    logic [SELW-1:0] tgt_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        sat_inc = (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic [NUM_OUT-1:0] lane_onehot(input logic [SELW-1:0] idx);
        logic [NUM_OUT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_OUT*WIDTH-1:0] lane_place(input logic [SELW-1:0] idx,
                                                            input logic [WIDTH-1:0] d);
        logic [NUM_OUT*WIDTH-1:0] r;
        r = '0;
        r[int'(idx)*WIDTH +: WIDTH] = d;
        return r;
    endfunction

    // in_ready follows the target lane's ready combinationally so a full buffer
    // can hand off and refill in the same cycle.
    always_comb begin
        xfer     = (state_p0 == HOLD) && out_ready[sel];
        in_ready = (state_p0 == IDLE) || xfer;
        capture  = in_valid && in_ready;
        rr_next  = (xfer && tgt_rr_p0) ? sel + SELW'(1) : rr_ptr_p0;
        tgt_next = rr_mode ? rr_next : in_dest;
    end

    // p0: holding register, lane outputs and bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0     <= IDLE;
            sel          <= '0;
            tgt_rr_p0    <= 1'b0;
            rr_ptr_p0    <= '0;
            word_cnt     <= '0;
            stall_cnt_p0 <= '0;
            stall        <= 1'b0;
            out_valid    <= '0;
            out_data     <= '0;
        end else begin
            rr_ptr_p0 <= rr_next;

            if (capture) begin
                state_p0  <= HOLD;
                sel       <= tgt_next;
                tgt_rr_p0 <= rr_mode;
                out_valid <= lane_onehot(tgt_next);
                out_data  <= lane_place(tgt_next, in_data);
            end else if (xfer) begin
                state_p0  <= IDLE;
                sel       <= '0;
                tgt_rr_p0 <= 1'b0;
                out_valid <= '0;
                out_data  <= '0;
            end

            // A refill without a hand-off never clears the stall state.
            if (xfer) begin
                word_cnt     <= word_cnt + 16'd1;
                stall_cnt_p0 <= '0;
                stall        <= 1'b0;
            end else if (state_p0 == HOLD) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
                if (int'(stall_cnt_p0) >= STALL_MAX) stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// Bench for demux_scheduler: directed vector table, hand sequences for reset/stall/wrap,
// and randomized traffic checked against a transaction-level model.
module tb_demux_scheduler;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SM = 15;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_dest;
    logic          rr_mode;
    logic [N-1:0]  out_valid;
    logic [N-1:0]  out_ready;
    logic [N*W-1:0] out_data;
    logic [1:0]    sel;
    logic [15:0]   word_cnt;
    logic          stall;

    int checks = 0;
    int errors = 0;

    // model state: the single buffered word and the scheduler bookkeeping
    bit m_full;
    int m_data;
    int m_lane;
    bit m_from_rr;
    int m_rr;
    int m_cnt;
    int m_wait;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [1:0]  dest;
        logic        m;
        logic [3:0]  ordy;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [1:0]  es;
        logic        er;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[22];

    demux_scheduler #(.WIDTH(W), .NUM_OUT(N), .STALL_MAX(SM)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel(sel), .word_cnt(word_cnt), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic [1:0] dest, input logic m, input logic [3:0] ordy);
        reset     = r;
        in_valid  = v;
        in_data   = d;
        in_dest   = dest;
        rr_mode   = m;
        out_ready = ordy;
    endtask

    task automatic check_model();
        logic [63:0] e;
        e = m_full ? (64'(m_data) << (W * m_lane)) : 64'd0;
        chk("m_valid", 64'(out_valid), m_full ? 64'(1 << m_lane) : 64'd0);
        chk("m_data", 64'(out_data), e);
        chk("m_sel", 64'(sel), m_full ? 64'(m_lane) : 64'd0);
        chk("m_in_ready", 64'(in_ready), 64'(!m_full || out_ready[m_lane]));
        chk("m_word_cnt", 64'(word_cnt), 64'(m_cnt));
        chk("m_stall", 64'(stall), 64'(m_wait > SM));
    endtask

    task automatic model_step();
        bit xfer;
        bit acc;
        if (reset) begin
            m_full = 0; m_data = 0; m_lane = 0; m_from_rr = 0;
            m_rr = 0; m_cnt = 0; m_wait = 0;
        end else begin
            xfer = m_full && out_ready[m_lane];
            acc  = in_valid && (!m_full || xfer);
            if (xfer) begin
                m_cnt  = (m_cnt + 1) % 65536;
                if (m_from_rr) m_rr = (m_lane + 1) % N;
                m_wait = 0;
            end else if (m_full) begin
                if (m_wait < 255) m_wait++;
            end
            if (acc) begin
                m_full    = 1;
                m_data    = int'(in_data);
                m_lane    = rr_mode ? m_rr : int'(in_dest);
                m_from_rr = rr_mode;
            end else if (xfer) begin
                m_full = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h10, 2'd0, 1'b1, 4'hF, 4'h0, 32'h00000000, 2'd0, 1'b1, 16'd0};
        tbl[1]  = '{1'b1, 8'h11, 2'd0, 1'b1, 4'hF, 4'h1, 32'h00000010, 2'd0, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 8'h12, 2'd0, 1'b1, 4'hF, 4'h2, 32'h00001100, 2'd1, 1'b1, 16'd1};
        tbl[3]  = '{1'b1, 8'h13, 2'd0, 1'b1, 4'hF, 4'h4, 32'h00120000, 2'd2, 1'b1, 16'd2};
        tbl[4]  = '{1'b1, 8'h14, 2'd0, 1'b1, 4'hF, 4'h8, 32'h13000000, 2'd3, 1'b1, 16'd3};
        tbl[5]  = '{1'b0, 8'h00, 2'd0, 1'b1, 4'hF, 4'h1, 32'h00000014, 2'd0, 1'b1, 16'd4};
        tbl[6]  = '{1'b0, 8'h00, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000000, 2'd0, 1'b1, 16'd5};
        tbl[7]  = '{1'b1, 8'h3C, 2'd3, 1'b0, 4'h7, 4'h0, 32'h00000000, 2'd0, 1'b1, 16'd5};
        tbl[8]  = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h7, 4'h8, 32'h3C000000, 2'd3, 1'b0, 16'd5};
        tbl[9]  = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h7, 4'h8, 32'h3C000000, 2'd3, 1'b0, 16'd5};
        tbl[10] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h7, 4'h8, 32'h3C000000, 2'd3, 1'b0, 16'd5};
        tbl[11] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h7, 4'h8, 32'h3C000000, 2'd3, 1'b0, 16'd5};
        tbl[12] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h8, 4'h8, 32'h3C000000, 2'd3, 1'b1, 16'd5};
        tbl[13] = '{1'b1, 8'h21, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000000, 2'd0, 1'b1, 16'd6};
        tbl[14] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h0, 4'h2, 32'h00002100, 2'd1, 1'b0, 16'd6};
        tbl[15] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'hD, 4'h2, 32'h00002100, 2'd1, 1'b0, 16'd6};
        tbl[16] = '{1'b1, 8'h55, 2'd3, 1'b0, 4'h2, 4'h2, 32'h00002100, 2'd1, 1'b1, 16'd6};
        tbl[17] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h0, 4'h8, 32'h55000000, 2'd3, 1'b0, 16'd7};
        tbl[18] = '{1'b0, 8'h00, 2'd3, 1'b0, 4'h8, 4'h8, 32'h55000000, 2'd3, 1'b1, 16'd7};
        tbl[19] = '{1'b1, 8'h66, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000000, 2'd0, 1'b1, 16'd8};
        tbl[20] = '{1'b0, 8'h00, 2'd0, 1'b1, 4'h4, 4'h4, 32'h00660000, 2'd2, 1'b1, 16'd8};
        tbl[21] = '{1'b0, 8'h00, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000000, 2'd0, 1'b1, 16'd9};

        // reset state
        drive(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
        tick();
        tick();
        drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_word_cnt", 64'(word_cnt), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // round-robin burst, directed backpressure, mode switch mid-hold
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, tbl[i].v, tbl[i].d, tbl[i].dest, tbl[i].m, tbl[i].ordy);
            @(negedge clk);
            check_model();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d_sel", i), 64'(sel), 64'(tbl[i].es));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].er));
            chk($sformatf("tbl%0d_word_cnt", i), 64'(word_cnt), 64'(tbl[i].ec));
            chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'd0);
            tick();
        end

        // reset while a word is held on lane 2
        drive(1'b0, 1'b1, 8'hA5, 2'd2, 1'b0, 4'h0);
        @(negedge clk); check_model(); tick();
        drive(1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 4'h0);
        @(negedge clk); check_model();
        chk("hold_a5_valid", 64'(out_valid), 64'h4);
        chk("hold_a5_data", 64'(out_data), 64'h00A50000);
        tick();
        drive(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
        @(negedge clk); check_model(); tick();
        drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        @(negedge clk); check_model();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        tick();
        @(negedge clk); check_model();
        chk("midrst_never_delivered", 64'(word_cnt), 64'd0);
        chk("midrst_still_idle", 64'(out_valid), 64'd0);
        tick();

        // stall flag on a blocked lane
        drive(1'b0, 1'b1, 8'h77, 2'd1, 1'b0, 4'h0);
        @(negedge clk); check_model(); tick();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 4'h0);
            @(negedge clk);
            check_model();
            if (k == 16) chk("stall_before_limit", 64'(stall), 64'd0);
            if (k == 17) chk("stall_rises", 64'(stall), 64'd1);
            if (k == 20) chk("stall_sticky", 64'(stall), 64'd1);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 4'h2);
        @(negedge clk); check_model();
        chk("stall_xfer_cycle", 64'(stall), 64'd1);
        chk("stall_xfer_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
        @(negedge clk); check_model();
        chk("stall_cleared", 64'(stall), 64'd0);
        chk("stall_delivered", 64'(word_cnt), 64'd1);
        tick();

        // randomized traffic with periodic blocked windows and occasional reset
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [3:0] ordy;
            r    = ($urandom_range(0, 99) == 0);
            ordy = ((i % 200) < 40) ? 4'h0 : 4'($urandom);
            drive(r, 1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), ordy);
            @(negedge clk);
            check_model();
            tick();
        end

        // streaming words until the delivered count wraps
        drive(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4'hF);
        @(negedge clk); check_model(); tick();
        for (int n = 0; n <= 65537; n++) begin
            drive(1'b0, 1'b1, 8'(n), 2'd0, 1'b1, 4'hF);
            @(negedge clk);
            check_model();
            if (n == 65536) chk("wrap_ffff", 64'(word_cnt), 64'hFFFF);
            if (n == 65537) chk("wrap_zero", 64'(word_cnt), 64'h0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
